spike_encoder: RTL

//  Rate-coding input stage that sits directly upstream of the spiking network core.
//  - Accepts one frame of N_INPUTS unsigned pixel intensities through a valid/ready handshake.
//  - Produces N_STEPS spike vectors for that frame, one per sample request from the network.
//  - A spike is drawn as Bernoulli(pixel/2^PIXEL_W), using a shared LFSR as the random source.

---
 rtl/spiker_pkg.sv | 17 +
 rtl/spike_lfsr16.sv | 21 ++
 rtl/spike_encoder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/spiker_pkg.sv
// Shared types and LFSR helper for the rate-coding spike encoder.
// Optional refractory masking is enabled with SPIKE_ENC_REFRACTORY_EN.
package spiker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GEN
    } enc_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/spike_lfsr16.sv
// 16-bit Galois LFSR, advances one step per cycle when adv is high.
module spike_lfsr16
    import spiker_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else if (adv) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/spike_encoder.sv
// Rate-coding encoder: one pixel frame in, N_STEPS Bernoulli spike vectors out.
// Define SPIKE_ENC_REFRACTORY_EN to suppress back-to-back spikes per input.
module spike_encoder
    import spiker_pkg::*;
#(
    parameter int          N_INPUTS   = 4,
    parameter int          PIXEL_W    = 8,
    parameter int          N_STEPS    = 10,
    parameter int          STEP_CNT_W = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic [N_INPUTS*PIXEL_W-1:0] pix_data,
    input  logic                        sample,
    output logic                        sample_ready,
    output logic [N_INPUTS-1:0]         spikes,
    output logic                        frame_done
);

    localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(N_STEPS - 1);
    localparam logic [15:0]           PIX_MASK  = 16'((32'd1 << PIXEL_W) - 1);

    enc_state_t                  state;
    logic [N_INPUTS*PIXEL_W-1:0] pix_q;
    logic [N_INPUTS*PIXEL_W-1:0] src;
    logic [STEP_CNT_W-1:0]       step;
    logic [15:0]                 lfsr_q;
    logic                        load;
    logic                        adv;
    logic [N_INPUTS-1:0]         cmp_vec;
    logic [N_INPUTS-1:0]         gen_vec;

    assign load = (state == IDLE) && pix_valid;
    assign adv  = load || (state == GEN);
    // Vector 0 is drawn in the load cycle, before pix_q holds the frame.
    assign src  = load ? pix_data : pix_q;

    spike_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk(clk),
        .rst(rst),
        .adv(adv),
        .q  (lfsr_q)
    );

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_cmp
        localparam int ROT = (3 * i) % 16;
        logic [15:0] rot;
        logic [15:0] pix;
        assign rot        = (lfsr_q << ROT) | (lfsr_q >> ((16 - ROT) % 16));
        assign pix        = 16'(src[i*PIXEL_W +: PIXEL_W]);
        assign cmp_vec[i] = pix > (rot & PIX_MASK);
    end

`ifdef SPIKE_ENC_REFRACTORY_EN
    logic [N_INPUTS-1:0] refr;

    assign gen_vec = load ? cmp_vec : (cmp_vec & ~refr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refr <= '0;
        end else if (adv) begin
            refr <= gen_vec;
        end
    end
`else
    assign gen_vec = cmp_vec;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pix_ready    <= 1'b1;
            sample_ready <= 1'b0;
            spikes       <= '0;
            frame_done   <= 1'b0;
            step         <= '0;
            pix_q        <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pix_valid) begin
                        pix_q        <= pix_data;
                        spikes       <= gen_vec;
                        step         <= '0;
                        pix_ready    <= 1'b0;
                        sample_ready <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (sample) begin
                        sample_ready <= 1'b0;
                        if (step == LAST_STEP) begin
                            spikes     <= '0;
                            frame_done <= 1'b1;
                            pix_ready  <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            step  <= step + 1'b1;
                            state <= GEN;
                        end
                    end
                end
                GEN: begin
                    spikes       <= gen_vec;
                    sample_ready <= 1'b1;
                    state        <= HOLD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
